// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Purpose : Bundles the two requester ports and the single-port data memory
//           bus of the data-memory arbiter.
// Signals :
//   p0_*/p1_*  requester side: req, we, addr[7:0], wdata[7:0] (to arbiter);
//              gnt, done, rdata[7:0] (from arbiter)
//   mem_*      memory side: addr[7:0], wdata[7:0], we, re (from arbiter);
//              rdata[7:0] (combinational read data from the memory)
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus the memory device)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic       p0_req;
  logic       p1_req;
  logic       p0_we;
  logic       p1_we;
  logic [7:0] p0_addr;
  logic [7:0] p1_addr;
  logic [7:0] p0_wdata;
  logic [7:0] p1_wdata;
  logic       p0_gnt;
  logic       p1_gnt;
  logic       p0_done;
  logic       p1_done;
  logic [7:0] p0_rdata;
  logic [7:0] p1_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Purpose : Two-requester arbiter in front of a single-port data memory.
//           Every access takes exactly two cycles: grant (IDLE), memory cycle
//           (ACCESS); the done pulse and read data appear in the following
//           cycle, in which a new grant may already be issued.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - dmem_arbiter_if.slave (requester ports p0/p1 and memory bus)
// Config  : define DMEM_ARB_ROUND_ROBIN_EN to alternate grants on ties
//           (port that was not granted most recently wins). Without it port 0
//           wins every tie and no last-winner register exists.
// -----------------------------------------------------------------------------
module dmem_arbiter (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       win_q, win_d;          // 0 = port 0 owns the access, 1 = port 1
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       p0_done_q, p0_done_d;
  logic       p1_done_q, p1_done_d;
  logic [7:0] p0_rdata_q, p0_rdata_d;
  logic [7:0] p1_rdata_q, p1_rdata_d;

  logic       pick0_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       mem_we_s;
  logic       mem_re_s;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;        // id of the most recently granted port
`endif

  // Arbitration decision: does port 0 win if a grant is issued this cycle
  always_comb begin
    pick0_s = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (bus.p0_req && bus.p1_req) begin
      // port 1 granted last -> port 0's turn
      pick0_s = last_q;
    end else begin
      pick0_s = bus.p0_req;
    end
`else
    pick0_s = bus.p0_req;
`endif
  end

  // FSM next state, grant generation, capture of the winning request
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          gnt0_s  = pick0_s;
          gnt1_s  = ~pick0_s;
          win_d   = ~pick0_s;
          we_d    = pick0_s ? bus.p0_we    : bus.p1_we;
          addr_d  = pick0_s ? bus.p0_addr  : bus.p1_addr;
          wdata_d = pick0_s ? bus.p0_wdata : bus.p1_wdata;
          state_d = ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_d  = ~pick0_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // request inputs are deliberately not looked at here
        mem_we_s = we_q;
        mem_re_s = ~we_q;
        state_d  = IDLE;
        if (win_q) begin
          p1_done_d = 1'b1;
          if (!we_q) begin
            p1_rdata_d = bus.mem_rdata;
          end else begin
            p1_rdata_d = p1_rdata_q;
          end
        end else begin
          p0_done_d = 1'b1;
          if (!we_q) begin
            p0_rdata_d = bus.mem_rdata;
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= 8'h00;
      p1_rdata_q <= 8'h00;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Grants and memory strobes are blanked while reset is held, so an access
  // interrupted by reset never reaches the memory.
  assign bus.p0_gnt    = gnt0_s & ~rst;
  assign bus.p1_gnt    = gnt1_s & ~rst;
  assign bus.mem_we    = mem_we_s & ~rst;
  assign bus.mem_re    = mem_re_s & ~rst;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.p0_done   = p0_done_q;
  assign bus.p1_done   = p1_done_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural memory device sits on
// the memory bus; a transaction-level reference (memory image, per-port read
// data, last winner) predicts grants, memory cycle, done and read data.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // memory device on the bus, plus reference image
  logic [7:0] ram     [0:255];
  logic [7:0] ref_mem [0:255];
  logic       ram_load = 1'b0;

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [7:0] exp_rdata [0:1];
  int         last_win;
  logic [7:0] last_addr;
  logic [7:0] last_wdata;

  task automatic chk1(input string tag, input logic got, input logic exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // arbitration rule: single requester wins; ties by mode
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return RR ? ((last_win == 1) ? 0 : 1) : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic drive(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  // one full access; entered and left at a falling edge
  task automatic txn(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                     input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    int         w;
    bit         we;
    logic [7:0] a;
    logic [7:0] d;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    w  = pick(r0, r1);
    we = (w == 1) ? w1 : w0;
    a  = (w == 1) ? a1 : a0;
    d  = (w == 1) ? d1 : d0;
    // cycle N: grant
    chk1("gnt0_N", bus.p0_gnt, w == 0);
    chk1("gnt1_N", bus.p1_gnt, w == 1);
    chk1("mem_we_N", bus.mem_we, 1'b0);
    chk1("mem_re_N", bus.mem_re, 1'b0);
    // cycle N+1: memory access, requests still held
    @(negedge clk); #1;
    chk1("gnt0_N1", bus.p0_gnt, 1'b0);
    chk1("gnt1_N1", bus.p1_gnt, 1'b0);
    chk1("mem_we_N1", bus.mem_we, we);
    chk1("mem_re_N1", bus.mem_re, !we);
    chk8("mem_addr_N1", bus.mem_addr, a);
    chk8("mem_wdata_N1", bus.mem_wdata, d);
    chk1("done0_N1", bus.p0_done, 1'b0);
    chk1("done1_N1", bus.p1_done, 1'b0);
    if (we) ref_mem[a] = d;
    else    exp_rdata[w] = ref_mem[a];
    last_win   = w;
    last_addr  = a;
    last_wdata = d;
    // cycle N+2: completion
    @(negedge clk);
    chk1("done0_N2", bus.p0_done, w == 0);
    chk1("done1_N2", bus.p1_done, w == 1);
    chk8("rdata0_N2", bus.p0_rdata, exp_rdata[0]);
    chk8("rdata1_N2", bus.p1_rdata, exp_rdata[1]);
    chk1("mem_we_N2", bus.mem_we, 1'b0);
    chk1("mem_re_N2", bus.mem_re, 1'b0);
    chk8("mem_addr_hold", bus.mem_addr, last_addr);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk1("idle_gnt0", bus.p0_gnt, 1'b0);
    chk1("idle_gnt1", bus.p1_gnt, 1'b0);
    chk1("idle_we", bus.mem_we, 1'b0);
    chk1("idle_re", bus.mem_re, 1'b0);
    chk8("idle_addr", bus.mem_addr, last_addr);
    chk8("idle_wdata", bus.mem_wdata, last_wdata);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_gnt0"}, bus.p0_gnt, 1'b0);
    chk1({tag, "_gnt1"}, bus.p1_gnt, 1'b0);
    chk1({tag, "_done0"}, bus.p0_done, 1'b0);
    chk1({tag, "_done1"}, bus.p1_done, 1'b0);
    chk8({tag, "_rdata0"}, bus.p0_rdata, 8'h00);
    chk8({tag, "_rdata1"}, bus.p1_rdata, 8'h00);
    chk1({tag, "_we"}, bus.mem_we, 1'b0);
    chk1({tag, "_re"}, bus.mem_re, 1'b0);
    chk8({tag, "_addr"}, bus.mem_addr, 8'h00);
    chk8({tag, "_wdata"}, bus.mem_wdata, 8'h00);
  endtask

  task automatic model_reset();
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    last_win     = 1;
    last_addr    = 8'h00;
    last_wdata   = 8'h00;
  endtask

  initial begin
    bit         r0, r1, w0, w1;
    logic [7:0] a0, a1, d0, d1;
    logic [7:0] old40;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h10] = 8'hA5;
    ref_mem[8'h20] = 8'h11;
    model_reset();

    // reset, with the memory image loaded meanwhile
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // contention from reset: both requests held
    for (int k = 0; k < 4; k++)
      txn(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h06, 8'h00);
    idle_cycle();

    // single read of a known word
    txn(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk8("read_A5", bus.p0_rdata, 8'hA5);
    idle_cycle();

    // single write by p1, then read back by p0
    txn(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
    idle_cycle();
    txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk8("readback_3C", bus.p0_rdata, 8'h3C);

    // back-to-back reads 0..3 from p0
    for (int k = 0; k < 4; k++)
      txn(1'b1, 1'b0, 8'(k), 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycle();

    // reset in the middle of a p1 write to 8'h40
    old40 = ref_mem[8'h40];
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, ~old40);
    #1;
    chk1("rst_mid_gnt1", bus.p1_gnt, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rst_mid_we", bus.mem_we, 1'b0);
    @(negedge clk);
    model_reset();
    chk_reset_state("rst_mid");
    chk8("rst_mid_mem40", ram[8'h40], old40);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("rst_mid_nodone", bus.p1_done, 1'b0);
    chk8("rst_mid_mem40_after", ram[8'h40], old40);
    rst = 1'b0;

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom_range(0, 15));
      a1 = 8'($urandom_range(0, 15));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      txn(r0, w0, a0, d0, r1, w1, a1, d1);
      if (k % 8 == 7) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
